// File: rtl/io_bus_arbiter_pkg.sv
// Types and widths shared by the slave-bus arbiter and its round-robin picker.
package io_bus_arbiter_pkg;

   typedef enum logic [2:0] {
      IDLE,
      GRANTED,
      ACTIVE,
      RELEASE,
      ABORT
   } arb_state_t;

   localparam int OWNER_W = 3;
   localparam int ADDR_W  = 8;
   localparam int DATA_W  = 32;

endpackage

// File: rtl/global_constants.sv
// Shared bus-wide constants used as parameter defaults across the slave bus blocks.
`ifndef GLOBAL_CONSTANTS_SV
`define GLOBAL_CONSTANTS_SV
`define BUS_TIMEOUT_DEFAULT 255
`define BUS_ERR_DATA 32'hDEAD_BEEF
`endif

// File: rtl/io_bus_arbiter_rr_priority_picker.sv
// Round-robin picker: first set request bit searching upward from last+1, wrapping.
module rr_priority_picker
   import io_bus_arbiter_pkg::*;
#(
   parameter int NUM_MASTERS = 2
) (
   input  logic [NUM_MASTERS-1:0] req,
   input  logic [OWNER_W-1:0]     last,
   output logic [OWNER_W-1:0]     idx,
   output logic                   valid
);

   logic [NUM_MASTERS-1:0] req_sh;
   int                     cand;

   always_comb begin
      idx    = '0;
      valid  = 1'b0;
      req_sh = '0;
      cand   = 0;
      // i runs 1..N so the previous owner is considered last
      for (int i = 1; i <= NUM_MASTERS; i++) begin
         cand   = (int'(last) + i) % NUM_MASTERS;
         req_sh = req >> cand;
         if (!valid && req_sh[0]) begin
            valid = 1'b1;
            idx   = OWNER_W'(cand);
         end
      end
   end

endmodule

// File: rtl/io_bus_arbiter.sv
// Shares the internal 4-phase slave bus between NUM_MASTERS masters with
// per-transaction round-robin grant and a slave-response watchdog.
`include "global_constants.sv"

module io_bus_arbiter
   import io_bus_arbiter_pkg::*;
#(
   parameter int          NUM_MASTERS    = 2,
   parameter int          TIMEOUT_CYCLES = `BUS_TIMEOUT_DEFAULT,
   parameter logic [31:0] ERR_DATA       = `BUS_ERR_DATA
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [NUM_MASTERS-1:0]    m_req,
   output logic [NUM_MASTERS-1:0]    m_grant,
   input  logic [NUM_MASTERS-1:0]    m_handshake_1,
   output logic [NUM_MASTERS-1:0]    m_handshake_2,
   input  logic [NUM_MASTERS-1:0]    m_RW,
   input  logic [8*NUM_MASTERS-1:0]  m_reg_address,
   input  logic [32*NUM_MASTERS-1:0] m_data_out,
   output logic [31:0]               m_data_in,
   output logic                      s_handshake_1,
   input  logic                      s_handshake_2,
   output logic                      s_RW,
   output logic [7:0]                s_reg_address,
   output logic [31:0]               s_data_out,
   input  logic [31:0]               s_data_in,
   output logic [2:0]                owner,
   output logic                      busy,
   output logic                      timeout_err,
   output logic [7:0]                err_count
);

   localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [NUM_MASTERS-1:0] ONE = {{(NUM_MASTERS-1){1'b0}}, 1'b1};

   arb_state_t             state, next;
   logic [OWNER_W-1:0]     owner_q;
   logic [TW-1:0]          timer;
   logic [7:0]             err_q;
   logic                   timeout_q;

   logic [OWNER_W-1:0]     pick_idx;
   logic                   pick_valid;
   logic [IW-1:0]          owner_idx;
   logic [NUM_MASTERS-1:0] owner_onehot;
   logic                   sel_req;
   logic                   sel_hs1;
   logic [8*NUM_MASTERS-1:0]  addr_sh;
   logic [32*NUM_MASTERS-1:0] data_sh;
   logic [NUM_MASTERS-1:0]    rw_sh;

   rr_priority_picker #(
      .NUM_MASTERS(NUM_MASTERS)
   ) u_picker (
      .req   (m_req),
      .last  (owner_q),
      .idx   (pick_idx),
      .valid (pick_valid)
   );

   // Owner-selected views of the master buses; only meaningful outside IDLE.
   assign owner_idx    = owner_q[IW-1:0];
   assign owner_onehot = ONE << owner_idx;
   assign sel_req      = m_req[owner_idx];
   assign sel_hs1      = m_handshake_1[owner_idx];
   assign addr_sh      = m_reg_address >> {owner_idx, 3'b000};
   assign data_sh      = m_data_out >> {owner_idx, 5'b00000};
   assign rw_sh        = m_RW >> owner_idx;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state     <= IDLE;
         owner_q   <= OWNER_W'(NUM_MASTERS - 1);
         timer     <= '0;
         err_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         state     <= next;
         timeout_q <= 1'b0;
         if (state == IDLE && pick_valid) begin
            owner_q <= pick_idx;
         end
         // Timer only counts inside ACTIVE, so GRANTED->ACTIVE always starts at zero
         timer <= (state == ACTIVE) ? timer + TW'(1) : '0;
         if (state == ACTIVE && next == ABORT) begin
            timeout_q <= 1'b1;
            if (err_q != 8'hFF) begin
               err_q <= err_q + 8'd1;
            end
         end
      end
   end

   always_comb begin
      next          = state;
      m_grant       = '0;
      m_handshake_2 = '0;
      m_data_in     = s_data_in;
      s_handshake_1 = 1'b0;
      s_RW          = 1'b0;
      s_reg_address = '0;
      s_data_out    = '0;
      if (state != IDLE) begin
         m_grant       = owner_onehot;
         s_RW          = rw_sh[0];
         s_reg_address = addr_sh[7:0];
         s_data_out    = data_sh[31:0];
      end
      case (state)
         IDLE: begin
            if (pick_valid) next = GRANTED;
         end
         GRANTED: begin
            if (sel_hs1)       next = ACTIVE;
            else if (!sel_req) next = IDLE;
         end
         ACTIVE: begin
            s_handshake_1 = 1'b1;
            m_handshake_2 = s_handshake_2 ? owner_onehot : '0;
            // Slave ack wins over a timeout landing in the same cycle
            if (s_handshake_2)             next = RELEASE;
            else if (timer == TIMER_LAST)  next = ABORT;
         end
         RELEASE: begin
            s_handshake_1 = sel_hs1;
            m_handshake_2 = s_handshake_2 ? owner_onehot : '0;
            if (!sel_hs1 && !s_handshake_2) next = IDLE;
         end
         ABORT: begin
            m_handshake_2 = owner_onehot;
            m_data_in     = ERR_DATA;
            if (!sel_hs1 && !s_handshake_2) next = IDLE;
         end
         default: next = IDLE;
      endcase
   end

   assign owner       = owner_q;
   assign busy        = (state != IDLE);
   assign timeout_err = timeout_q;
   assign err_count   = err_q;

endmodule

// File: tb/tb_io_bus_arbiter.sv
// Directed bench for io_bus_arbiter: grant/data scoreboards, timeout, abandon, reset, tie.
module tb_io_bus_arbiter;

   localparam int          N   = 2;
   localparam int          TO  = 8;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;

   logic              clk = 1'b0;
   logic              reset;
   logic [N-1:0]      m_req;
   logic [N-1:0]      m_grant;
   logic [N-1:0]      m_handshake_1;
   logic [N-1:0]      m_handshake_2;
   logic [N-1:0]      m_RW;
   logic [8*N-1:0]    m_reg_address;
   logic [32*N-1:0]   m_data_out;
   logic [31:0]       m_data_in;
   logic              s_handshake_1;
   logic              s_handshake_2;
   logic              s_RW;
   logic [7:0]        s_reg_address;
   logic [31:0]       s_data_out;
   logic [31:0]       s_data_in;
   logic [2:0]        owner;
   logic              busy;
   logic              timeout_err;
   logic [7:0]        err_count;

   int checks = 0;
   int errors = 0;
   logic [31:0] grant_q[$];
   logic [31:0] data_q[$];

   io_bus_arbiter #(
      .NUM_MASTERS(N),
      .TIMEOUT_CYCLES(TO),
      .ERR_DATA(ERR)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .m_req         (m_req),
      .m_grant       (m_grant),
      .m_handshake_1 (m_handshake_1),
      .m_handshake_2 (m_handshake_2),
      .m_RW          (m_RW),
      .m_reg_address (m_reg_address),
      .m_data_out    (m_data_out),
      .m_data_in     (m_data_in),
      .s_handshake_1 (s_handshake_1),
      .s_handshake_2 (s_handshake_2),
      .s_RW          (s_RW),
      .s_reg_address (s_reg_address),
      .s_data_out    (s_data_out),
      .s_data_in     (s_data_in),
      .owner         (owner),
      .busy          (busy),
      .timeout_err   (timeout_err),
      .err_count     (err_count)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [N-1:0] bit_of(input int m);
      logic [N-1:0] one;
      one = 1;
      return one << m;
   endfunction

   // Ticks until a grant shows up; every arbitration should take exactly one cycle.
   task automatic wait_grant();
      logic [31:0] exp;
      int          lat;
      lat = 0;
      for (int k = 0; k < 6; k++) begin
         tick();
         lat++;
         if (m_grant !== '0) break;
      end
      exp = (grant_q.size() != 0) ? grant_q.pop_front() : 32'hFFFF_FFFF;
      check("grant_latency", 32'(lat), 32'd1);
      check("grant_onehot", 32'(m_grant), 32'(bit_of(int'(exp))));
      check("owner", 32'(owner), exp);
   endtask

   // Full write/read transaction for an already-granted master m.
   task automatic txn(input int m, input logic [7:0] addr, input logic [31:0] wdata,
                      input logic [31:0] rdata, input int ack_delay, input bit drop_req);
      data_q.push_back(rdata);
      m_reg_address[m*8 +: 8]  = addr;
      m_data_out[m*32 +: 32]   = wdata;
      m_RW          = m_RW | bit_of(m);
      m_handshake_1 = m_handshake_1 | bit_of(m);
      #1;
      check("granted_addr", 32'(s_reg_address), 32'(addr));
      tick();
      check("active_hs1", 32'(s_handshake_1), 32'd1);
      check("active_addr", 32'(s_reg_address), 32'(addr));
      check("active_data", s_data_out, wdata);
      check("active_rw", 32'(s_RW), 32'd1);
      check("active_no_ack", 32'(m_handshake_2), 32'd0);
      repeat (ack_delay) tick();
      check("pre_ack_addr", 32'(s_reg_address), 32'(addr));
      s_handshake_2 = 1'b1;
      s_data_in     = rdata;
      #1;
      check("ack_fwd", 32'(m_handshake_2), 32'(bit_of(m)));
      check("rdata", m_data_in, data_q.pop_front());
      tick();
      check("release_hs1", 32'(s_handshake_1), 32'd1);
      m_handshake_1 = m_handshake_1 & ~bit_of(m);
      if (drop_req) m_req = m_req & ~bit_of(m);
      #1;
      check("release_hs1_drop", 32'(s_handshake_1), 32'd0);
      check("release_ack", 32'(m_handshake_2), 32'(bit_of(m)));
      s_handshake_2 = 1'b0;
      tick();
      check("idle_busy", 32'(busy), 32'd0);
      check("idle_grant", 32'(m_grant), 32'd0);
      check("idle_addr", 32'(s_reg_address), 32'd0);
   endtask

   initial begin
      reset         = 1'b0;
      m_req         = '0;
      m_handshake_1 = '0;
      m_RW          = '0;
      m_reg_address = '0;
      m_data_out    = '0;
      s_handshake_2 = 1'b0;
      s_data_in     = '0;
      tick();
      tick();
      reset = 1'b1;
      check("rst_grant", 32'(m_grant), 32'd0);
      check("rst_owner", 32'(owner), 32'(N - 1));
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_err_count", 32'(err_count), 32'd0);
      check("rst_s_hs1", 32'(s_handshake_1), 32'd0);
      check("rst_timeout", 32'(timeout_err), 32'd0);

      // single request from master 0, slave acks after 3 cycles
      m_req = 2'b01;
      grant_q.push_back(32'd0);
      wait_grant();
      txn(0, 8'h12, 32'h0000_00FF, 32'h1234_5678, 3, 1'b1);

      // contention: both masters hold request for four transactions
      reset = 1'b0;
      tick();
      reset = 1'b1;
      m_req = 2'b11;
      grant_q.push_back(32'd0);
      grant_q.push_back(32'd1);
      grant_q.push_back(32'd0);
      grant_q.push_back(32'd1);
      for (int t = 0; t < 4; t++) begin
         wait_grant();
         txn(t % 2, 8'(8'h40 + t), 32'($urandom_range(0, 32'hFFFF)),
             32'($urandom), $urandom_range(0, 3), 1'b0);
      end
      m_req = '0;
      tick();

      // timeout: owner wraps 1 -> 0, slave never acks
      m_req = 2'b01;
      grant_q.push_back(32'd0);
      wait_grant();
      m_handshake_1 = 2'b01;
      tick();
      for (int k = 1; k < TO; k++) begin
         tick();
         check("no_early_timeout", 32'(timeout_err), 32'd0);
      end
      tick();
      check("to_pulse", 32'(timeout_err), 32'd1);
      check("to_data", m_data_in, ERR);
      check("to_ack", 32'(m_handshake_2), 32'b01);
      check("to_err_count", 32'(err_count), 32'd1);
      check("to_s_hs1", 32'(s_handshake_1), 32'd0);
      tick();
      check("to_pulse_end", 32'(timeout_err), 32'd0);
      check("to_still_busy", 32'(busy), 32'd1);
      m_handshake_1 = '0;
      m_req         = '0;
      tick();
      check("to_recover", 32'(busy), 32'd0);

      // abandon: master 1 granted then drops request, master 0 waiting
      m_req = 2'b10;
      grant_q.push_back(32'd1);
      wait_grant();
      m_req = 2'b01;
      tick();
      check("abandon_grant", 32'(m_grant), 32'd0);
      check("abandon_busy", 32'(busy), 32'd0);
      grant_q.push_back(32'd0);
      wait_grant();
      m_req = '0;
      tick();
      check("abandon2_busy", 32'(busy), 32'd0);

      // reset while ACTIVE
      m_req = 2'b10;
      grant_q.push_back(32'd1);
      wait_grant();
      m_handshake_1 = 2'b10;
      tick();
      check("pre_rst_active", 32'(s_handshake_1), 32'd1);
      reset = 1'b0;
      tick();
      check("midrst_s_hs1", 32'(s_handshake_1), 32'd0);
      check("midrst_grant", 32'(m_grant), 32'd0);
      check("midrst_err_count", 32'(err_count), 32'd0);
      check("midrst_owner", 32'(owner), 32'(N - 1));
      check("midrst_m_hs2", 32'(m_handshake_2), 32'd0);
      reset         = 1'b1;
      m_req         = '0;
      m_handshake_1 = '0;
      tick();

      // ack arrives in the same cycle the timer hits its limit
      m_req = 2'b01;
      grant_q.push_back(32'd0);
      wait_grant();
      m_handshake_1 = 2'b01;
      tick();
      repeat (TO - 1) tick();
      check("tie_still_active", 32'(s_handshake_1), 32'd1);
      s_handshake_2 = 1'b1;
      s_data_in     = 32'hCAFE_0001;
      data_q.push_back(32'hCAFE_0001);
      tick();
      check("tie_no_timeout", 32'(timeout_err), 32'd0);
      check("tie_err_count", 32'(err_count), 32'd0);
      check("tie_release_hs1", 32'(s_handshake_1), 32'd1);
      check("tie_ack", 32'(m_handshake_2), 32'b01);
      check("tie_rdata", m_data_in, data_q.pop_front());
      m_handshake_1 = '0;
      m_req         = '0;
      s_handshake_2 = 1'b0;
      tick();
      check("tie_idle", 32'(busy), 32'd0);
      tick();
      check("tie_no_late_timeout", 32'(timeout_err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
